// File: rtl/imem_arbiter_pkg.sv
// Shared types for the instruction-memory arbiter: requester ids and routing entries.
package imem_arbiter_pkg;

  localparam int unsigned MAX_OUTSTANDING_DEF = 4;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_AUX   = 1'b1
  } port_id_e;

  typedef struct packed {
    port_id_e port_id;
    logic     discard;
  } route_entry_t;

  // One-hot per-port vector for a requester id
  function automatic logic [1:0] port_onehot(input port_id_e p);
    return (p == PORT_AUX) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/imem_route_fifo.sv
// In-order routing FIFO recording the owner of each in-flight memory request.
// flush_mark_i sets discard on every fetch-owned entry; a push in the same
// cycle lands unmarked.
module imem_route_fifo
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_OUTSTANDING_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  route_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_mark_i,
  output route_entry_t head_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  route_entry_t  mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Read/write pointers with wrap bit
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Entry storage: flush marking first, so a same-cycle push overrides it
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (flush_mark_i && (mem_q[i].port_id == PORT_FETCH)) mem_q[i].discard <= 1'b1;
    end
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
  end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing the instruction-memory port between fetch (port 0)
// and an auxiliary requester (port 1), with in-order response routing and
// fetch flush. Optional performance counters: define IMEM_ARBITER_PERF_EN.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned XLEN                 = 32,
  parameter int unsigned INSTR_MEM_ADDR_WIDTH = 16,
  parameter int unsigned INSTR_MEM_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING      = MAX_OUTSTANDING_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      req_valid,
  output logic [1:0]                      req_ready,
  input  logic [INSTR_MEM_ADDR_WIDTH-1:0] req_addr0,
  input  logic [INSTR_MEM_ADDR_WIDTH-1:0] req_addr1,
  input  logic [XLEN-1:0]                 req_tag0,
  input  logic [XLEN-1:0]                 req_tag1,
  input  logic                            fetch_flush,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0] instr_mem_addr,
  output logic                            instr_mem_addr_valid,
  output logic [XLEN-1:0]                 instr_mem_tag_out,
  input  logic [INSTR_MEM_WIDTH-1:0]      instr_mem_rdata,
  input  logic                            instr_mem_rdata_valid,
  input  logic [XLEN-1:0]                 instr_mem_tag_in,
  output logic [1:0]                      resp_valid,
  output logic [INSTR_MEM_WIDTH-1:0]      resp_rdata,
  output logic [XLEN-1:0]                 resp_tag,
`ifdef IMEM_ARBITER_PERF_EN
  output logic [31:0]                     perf_grants0,
  output logic [31:0]                     perf_grants1,
  output logic [31:0]                     perf_full_stalls,
`endif
  output logic                            err_unexpected
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]                   cnt_q, cnt_d;
  port_id_e                        last_q;
  logic                            addr_valid_q;
  logic [INSTR_MEM_ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]                 tag_q;
  logic                            err_q;

  logic         slot_free;
  logic         gnt_any;
  port_id_e     gnt_port;
  logic         pop;
  logic         drop;
  route_entry_t head;
  logic         fifo_empty;
  logic         fifo_full;

  // fifo_full tracks cnt saturation; both gate acceptance
  assign slot_free = (cnt_q < CNT_MAX) && !fifo_full;

  // Round-robin grant: on contention the port not granted last wins
  always_comb begin
    gnt_any  = 1'b0;
    gnt_port = PORT_FETCH;
    if (!rst && slot_free) begin
      if (&req_valid) begin
        gnt_any  = 1'b1;
        gnt_port = (last_q == PORT_FETCH) ? PORT_AUX : PORT_FETCH;
      end else if (req_valid[0]) begin
        gnt_any  = 1'b1;
        gnt_port = PORT_FETCH;
      end else if (req_valid[1]) begin
        gnt_any  = 1'b1;
        gnt_port = PORT_AUX;
      end
    end
  end

  assign req_ready = gnt_any ? port_onehot(gnt_port) : 2'b00;

  // Response steering: flush also drops a fetch response popped this cycle
  assign pop        = instr_mem_rdata_valid && !fifo_empty && !rst;
  assign drop       = head.discard || (fetch_flush && (head.port_id == PORT_FETCH));
  assign resp_valid = (pop && !drop) ? port_onehot(head.port_id) : 2'b00;
  assign resp_rdata = instr_mem_rdata;
  assign resp_tag   = instr_mem_tag_in;

  imem_route_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_route_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (gnt_any),
    .push_entry_i ('{port_id: gnt_port, discard: 1'b0}),
    .pop_i        (pop),
    .flush_mark_i (fetch_flush && !rst),
    .head_o       (head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

  // Outstanding count: simultaneous accept and response leaves it unchanged
  always_comb begin
    cnt_d = cnt_q;
    if (gnt_any && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!gnt_any && pop) cnt_d = cnt_q - CW'(1);
  end

  // Output register, arbitration pointer, count and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_valid_q <= 1'b0;
      addr_q       <= '0;
      tag_q        <= '0;
      last_q       <= PORT_AUX;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      addr_valid_q <= gnt_any;
      if (gnt_any) begin
        addr_q <= (gnt_port == PORT_AUX) ? req_addr1 : req_addr0;
        tag_q  <= (gnt_port == PORT_AUX) ? req_tag1 : req_tag0;
        last_q <= gnt_port;
      end
      cnt_q <= cnt_d;
      if (instr_mem_rdata_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign instr_mem_addr_valid = addr_valid_q;
  assign instr_mem_addr       = addr_q;
  assign instr_mem_tag_out    = tag_q;
  assign err_unexpected       = err_q;

`ifdef IMEM_ARBITER_PERF_EN
  logic [31:0] grants0_q, grants1_q, stalls_q;

  // Saturating grant and full-stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      grants0_q <= '0;
      grants1_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (gnt_any && (gnt_port == PORT_FETCH) && !(&grants0_q)) grants0_q <= grants0_q + 32'd1;
      if (gnt_any && (gnt_port == PORT_AUX) && !(&grants1_q))   grants1_q <= grants1_q + 32'd1;
      if ((|req_valid) && (cnt_q == CNT_MAX) && !(&stalls_q))   stalls_q  <= stalls_q + 32'd1;
    end
  end

  assign perf_grants0     = grants0_q;
  assign perf_grants1     = grants1_q;
  assign perf_full_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a small in-order memory model.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [15:0] req_addr0 = '0, req_addr1 = '0;
  logic [31:0] req_tag0 = '0, req_tag1 = '0;
  logic        fetch_flush = 1'b0;
  logic [15:0] instr_mem_addr;
  logic        instr_mem_addr_valid;
  logic [31:0] instr_mem_tag_out;
  logic [31:0] instr_mem_rdata = '0;
  logic        instr_mem_rdata_valid = 1'b0;
  logic [31:0] instr_mem_tag_in = '0;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata, resp_tag;
  logic        err_unexpected;
`ifdef IMEM_ARBITER_PERF_EN
  logic [31:0] perf_grants0, perf_grants1, perf_full_stalls;
`endif

  int n_vec = 0;
  int n_miscmp = 0;
  int cyc = 0;

  int mem_lat  = 1;
  bit mem_hold = 1'b0;
  bit mem_keep = 1'b0;
  bit inject   = 1'b0;

  typedef struct {
    logic [31:0] tag;
    logic [15:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  logic [63:0] r0q[$];
  logic [63:0] r1q[$];

  imem_arbiter dut (
    .clk                   (clk),
    .rst                   (rst),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_addr0             (req_addr0),
    .req_addr1             (req_addr1),
    .req_tag0              (req_tag0),
    .req_tag1              (req_tag1),
    .fetch_flush           (fetch_flush),
    .instr_mem_addr        (instr_mem_addr),
    .instr_mem_addr_valid  (instr_mem_addr_valid),
    .instr_mem_tag_out     (instr_mem_tag_out),
    .instr_mem_rdata       (instr_mem_rdata),
    .instr_mem_rdata_valid (instr_mem_rdata_valid),
    .instr_mem_tag_in      (instr_mem_tag_in),
    .resp_valid            (resp_valid),
    .resp_rdata            (resp_rdata),
    .resp_tag              (resp_tag),
`ifdef IMEM_ARBITER_PERF_EN
    .perf_grants0          (perf_grants0),
    .perf_grants1          (perf_grants1),
    .perf_full_stalls      (perf_full_stalls),
`endif
    .err_unexpected        (err_unexpected)
  );

  always #5 clk = ~clk;

  // Memory model: captures strobes, answers in order after mem_lat cycles
  always @(negedge clk) begin
    instr_mem_rdata_valid = 1'b0;
    if (rst && !mem_keep) mq.delete();
    if (instr_mem_addr_valid === 1'b1)
      mq.push_back('{tag: instr_mem_tag_out, addr: instr_mem_addr, due: cyc + mem_lat});
    if (inject) begin
      instr_mem_rdata_valid = 1'b1;
      instr_mem_tag_in      = 32'hDEAD;
      instr_mem_rdata       = 32'hBAD0BAD0;
    end else if (!mem_hold && mq.size() > 0 && mq[0].due <= cyc) begin
      instr_mem_rdata_valid = 1'b1;
      instr_mem_tag_in      = mq[0].tag;
      instr_mem_rdata       = {16'hC0DE, mq[0].addr};
      void'(mq.pop_front());
    end
  end

  // Response logger
  always @(negedge clk) begin
    #1;
    cyc++;
    if (resp_valid[0] === 1'b1) r0q.push_back({resp_tag, resp_rdata});
    if (resp_valid[1] === 1'b1) r1q.push_back({resp_tag, resp_rdata});
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00; fetch_flush = 1'b0;
    @(negedge clk);
    mem_hold = 1'b0; inject = 1'b0; mem_keep = 1'b0; mq.delete();
    @(negedge clk);
    rst = 1'b0; r0q.delete(); r1q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11;
    @(negedge clk); @(negedge clk); #1;
    n_vec++; if (req_ready !== 2'b00) begin n_miscmp++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    n_vec++; if (instr_mem_addr_valid !== 1'b0) begin n_miscmp++; $display("FAIL reset_addr_valid got %b exp 0", instr_mem_addr_valid); end
    n_vec++; if (instr_mem_addr !== 16'h0) begin n_miscmp++; $display("FAIL reset_addr got %h exp 0000", instr_mem_addr); end
    n_vec++; if (instr_mem_tag_out !== 32'h0) begin n_miscmp++; $display("FAIL reset_tag got %h exp 0", instr_mem_tag_out); end
    n_vec++; if (resp_valid !== 2'b00) begin n_miscmp++; $display("FAIL reset_resp_valid got %b exp 00", resp_valid); end
    n_vec++; if (err_unexpected !== 1'b0) begin n_miscmp++; $display("FAIL reset_err got %b exp 0", err_unexpected); end
    req_valid = 2'b00;
  endtask

  task automatic test_fetch_stream();
    int t;
    do_reset();
    mem_lat = 2;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      req_valid = (i < 8) ? 2'b01 : 2'b00;
      req_addr0 = 16'(4 * i);
      req_tag0  = 32'h100 + 32'(i);
      #1;
      if (i < 8) begin
        n_vec++;
        if (req_ready !== 2'b01) begin n_miscmp++; $display("FAIL stream_ready[%0d] got %b exp 01", i, req_ready); end
      end
      n_vec++;
      if (i == 0) begin
        if (instr_mem_addr_valid !== 1'b0) begin n_miscmp++; $display("FAIL stream_strobe0 got %b exp 0", instr_mem_addr_valid); end
      end else if (instr_mem_addr_valid !== 1'b1 || instr_mem_addr !== 16'(4 * (i - 1)) ||
                   instr_mem_tag_out !== 32'h100 + 32'(i - 1)) begin
        n_miscmp++;
        $display("FAIL stream_strobe[%0d] got v=%b a=%h t=%h exp v=1 a=%h t=%h", i, instr_mem_addr_valid,
                 instr_mem_addr, instr_mem_tag_out, 16'(4 * (i - 1)), 32'h100 + 32'(i - 1));
      end
    end
    t = 0;
    while (r0q.size() < 8 && t < 40) begin @(negedge clk); #2; t++; end
    n_vec++;
    if (r0q.size() != 8 || r1q.size() != 0) begin
      n_miscmp++; $display("FAIL stream_resp_count got %0d/%0d exp 8/0", r0q.size(), r1q.size());
    end
    for (int k = 0; k < r0q.size() && k < 8; k++) begin
      n_vec++;
      if (r0q[k] !== {32'h100 + 32'(k), 32'hC0DE0000 + 32'(4 * k)}) begin
        n_miscmp++; $display("FAIL stream_resp[%0d] got %h exp %h", k, r0q[k], {32'h100 + 32'(k), 32'hC0DE0000 + 32'(4 * k)});
      end
    end
  endtask

  task automatic test_round_robin();
    int f = 0, a = 0, t;
    logic [1:0] exp;
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid = 2'b11;
      req_addr0 = 16'h1000 + 16'(4 * f); req_tag0 = 32'hF00 + 32'(f);
      req_addr1 = 16'h2000 + 16'(4 * a); req_tag1 = 32'hA00 + 32'(a);
      #1;
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_vec++;
      if (req_ready !== exp) begin n_miscmp++; $display("FAIL rr_grant[%0d] got %b exp %b", i, req_ready, exp); end
      if (req_ready[0] === 1'b1) f++;
      if (req_ready[1] === 1'b1) a++;
    end
    @(negedge clk);
    req_valid = 2'b00;
    t = 0;
    while ((r0q.size() < 3 || r1q.size() < 3) && t < 30) begin @(negedge clk); #2; t++; end
    n_vec++;
    if (r0q.size() != 3 || r1q.size() != 3) begin
      n_miscmp++; $display("FAIL rr_resp_count got %0d/%0d exp 3/3", r0q.size(), r1q.size());
    end
    for (int k = 0; k < 3 && k < r0q.size() && k < r1q.size(); k++) begin
      n_vec++;
      if (r0q[k] !== {32'hF00 + 32'(k), 32'hC0DE1000 + 32'(4 * k)}) begin
        n_miscmp++; $display("FAIL rr_fetch_resp[%0d] got %h", k, r0q[k]);
      end
      n_vec++;
      if (r1q[k] !== {32'hA00 + 32'(k), 32'hC0DE2000 + 32'(4 * k)}) begin
        n_miscmp++; $display("FAIL rr_aux_resp[%0d] got %h", k, r1q[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0, t;
    logic [1:0] exp;
    do_reset();
    mem_lat = 1;
    #2 mem_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 2'b01; req_addr0 = 16'h0040; req_tag0 = 32'h200 + 32'(acc);
      #1;
      exp = (i < 4 || i == 9) ? 2'b01 : 2'b00;
      n_vec++;
      if (req_ready !== exp) begin n_miscmp++; $display("FAIL bp_ready[%0d] got %b exp %b", i, req_ready, exp); end
      if (i == 8) begin
        n_vec++;
        if (resp_valid !== 2'b01 || resp_tag !== 32'h200) begin
          n_miscmp++; $display("FAIL bp_first_resp got v=%b t=%h exp v=01 t=00000200", resp_valid, resp_tag);
        end
      end
      if (req_ready[0] === 1'b1) acc++;
      if (i == 7) #1 mem_hold = 1'b0;
    end
    @(negedge clk);
    req_valid = 2'b00;
    t = 0;
    while (r0q.size() < 5 && t < 30) begin @(negedge clk); #2; t++; end
    n_vec++;
    if (r0q.size() != 5) begin n_miscmp++; $display("FAIL bp_resp_count got %0d exp 5", r0q.size()); end
    for (int k = 0; k < r0q.size() && k < 5; k++) begin
      n_vec++;
      if (r0q[k][63:32] !== 32'h200 + 32'(k)) begin
        n_miscmp++; $display("FAIL bp_resp_tag[%0d] got %h exp %h", k, r0q[k][63:32], 32'h200 + 32'(k));
      end
    end
  endtask

  task automatic test_flush();
    int t;
    do_reset();
    mem_lat = 1;
    #2 mem_hold = 1'b1;
    @(negedge clk); req_valid = 2'b01; req_addr0 = 16'h0300; req_tag0 = 32'h300; #1;
    n_vec++; if (req_ready !== 2'b01) begin n_miscmp++; $display("FAIL flush_ready_f0 got %b exp 01", req_ready); end
    @(negedge clk); req_valid = 2'b10; req_addr1 = 16'h03A0; req_tag1 = 32'h3A0; #1;
    n_vec++; if (req_ready !== 2'b10) begin n_miscmp++; $display("FAIL flush_ready_a0 got %b exp 10", req_ready); end
    @(negedge clk); req_valid = 2'b01; req_addr0 = 16'h0304; req_tag0 = 32'h301; #1;
    n_vec++; if (req_ready !== 2'b01) begin n_miscmp++; $display("FAIL flush_ready_f1 got %b exp 01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); req_valid = 2'b01; req_addr0 = 16'h0308; req_tag0 = 32'h302; fetch_flush = 1'b1; #1;
    n_vec++; if (req_ready !== 2'b01) begin n_miscmp++; $display("FAIL flush_ready_new got %b exp 01", req_ready); end
    @(negedge clk); req_valid = 2'b00; fetch_flush = 1'b0;
    #2 mem_hold = 1'b0;
    t = 0;
    while ((r0q.size() < 1 || r1q.size() < 1) && t < 30) begin @(negedge clk); #2; t++; end
    repeat (5) @(negedge clk);
    #2;
    n_vec++;
    if (r0q.size() != 1 || r1q.size() != 1) begin
      n_miscmp++; $display("FAIL flush_resp_count got %0d/%0d exp 1/1", r0q.size(), r1q.size());
    end
    if (r0q.size() > 0) begin
      n_vec++;
      if (r0q[0] !== {32'h302, 32'hC0DE0308}) begin n_miscmp++; $display("FAIL flush_fetch_resp got %h exp %h", r0q[0], {32'h302, 32'hC0DE0308}); end
    end
    if (r1q.size() > 0) begin
      n_vec++;
      if (r1q[0] !== {32'h3A0, 32'hC0DE03A0}) begin n_miscmp++; $display("FAIL flush_aux_resp got %h exp %h", r1q[0], {32'h3A0, 32'hC0DE03A0}); end
    end
  endtask

  task automatic test_unexpected();
    logic [1:0] exp;
    do_reset();
    #2 inject = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (resp_valid !== 2'b00) begin n_miscmp++; $display("FAIL unexp_resp_valid got %b exp 00", resp_valid); end
    n_vec++; if (err_unexpected !== 1'b0) begin n_miscmp++; $display("FAIL unexp_err_early got %b exp 0", err_unexpected); end
    #1 inject = 1'b0;
    @(negedge clk); #1;
    n_vec++; if (err_unexpected !== 1'b1) begin n_miscmp++; $display("FAIL unexp_err_set got %b exp 1", err_unexpected); end
    #1 mem_hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid = 2'b01; req_tag0 = 32'h500 + 32'(i); #1;
      exp = (i < 4) ? 2'b01 : 2'b00;
      n_vec++;
      if (req_ready !== exp) begin n_miscmp++; $display("FAIL unexp_cnt_ready[%0d] got %b exp %b", i, req_ready, exp); end
    end
    @(negedge clk); req_valid = 2'b00; #1;
    n_vec++; if (err_unexpected !== 1'b1) begin n_miscmp++; $display("FAIL unexp_err_sticky got %b exp 1", err_unexpected); end
    n_vec++; if (r0q.size() != 0) begin n_miscmp++; $display("FAIL unexp_no_resp got %0d exp 0", r0q.size()); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    mem_lat = 1;
    #2 begin mem_hold = 1'b1; mem_keep = 1'b1; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 2'b01; req_addr0 = 16'h0400 + 16'(4 * i); req_tag0 = 32'h400 + 32'(i); #1;
      n_vec++;
      if (req_ready !== 2'b01) begin n_miscmp++; $display("FAIL mid_ready[%0d] got %b exp 01", i, req_ready); end
    end
    @(negedge clk); rst = 1'b1; req_valid = 2'b01; req_tag0 = 32'h403; #1;
    n_vec++; if (req_ready !== 2'b00) begin n_miscmp++; $display("FAIL mid_ready_in_rst got %b exp 00", req_ready); end
    @(negedge clk); rst = 1'b0; req_valid = 2'b00; #1;
    n_vec++;
    if (instr_mem_addr_valid !== 1'b0 || instr_mem_addr !== 16'h0 || instr_mem_tag_out !== 32'h0 ||
        resp_valid !== 2'b00 || err_unexpected !== 1'b0) begin
      n_miscmp++;
      $display("FAIL mid_outputs got v=%b a=%h t=%h r=%b e=%b exp all 0", instr_mem_addr_valid,
               instr_mem_addr, instr_mem_tag_out, resp_valid, err_unexpected);
    end
`ifdef IMEM_ARBITER_PERF_EN
    n_vec++;
    if (perf_grants0 !== 32'h0 || perf_grants1 !== 32'h0 || perf_full_stalls !== 32'h0) begin
      n_miscmp++; $display("FAIL mid_perf got %h %h %h exp 0", perf_grants0, perf_grants1, perf_full_stalls);
    end
`endif
    #1 mem_hold = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    n_vec++; if (err_unexpected !== 1'b1) begin n_miscmp++; $display("FAIL mid_late_err got %b exp 1", err_unexpected); end
    n_vec++; if (r0q.size() != 0 || r1q.size() != 0) begin
      n_miscmp++; $display("FAIL mid_late_resp got %0d/%0d exp 0/0", r0q.size(), r1q.size());
    end
    mem_keep = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_unexpected();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-requester arbiter that shares the single instruction-memory port between the instruction fetch unit (port 0, "fetch") and an auxiliary requester such as a program loader or debug reader (port 1, "aux").
- Arbitrates round-robin and registers the winning request onto the memory port.
- Tracks in-flight requests in an in-order routing FIFO and steers each returning response to its owner.
- Supports a fetch flush that silently discards stale fetch responses.
- Sits between the fetch unit and the instruction memory.

## Interface
Parameters:
- XLEN, 32, request/response tag width
- INSTR_MEM_ADDR_WIDTH, 16, memory address width
- INSTR_MEM_WIDTH, 32, memory read-data width
- MAX_OUTSTANDING, 4, in-flight request limit; power of two, 2..16

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- req_valid[1:0]  in  2  request valid per port (0 = fetch, 1 = aux)
- req_ready[1:0]  out  2  request accepted this cycle when valid & ready
- req_addr0 / req_addr1  in  INSTR_MEM_ADDR_WIDTH  request address
- req_tag0 / req_tag1  in  XLEN  requester tag, returned unchanged
- fetch_flush  in  1  discard all in-flight fetch responses
- instr_mem_addr  out  INSTR_MEM_ADDR_WIDTH  memory address
- instr_mem_addr_valid  out  1  memory request strobe; memory always accepts
- instr_mem_tag_out  out  XLEN  tag sent with request
- instr_mem_rdata  in  INSTR_MEM_WIDTH  response data
- instr_mem_rdata_valid  in  1  response strobe; responses return in request order
- instr_mem_tag_in  in  XLEN  response tag
- resp_valid[1:0]  out  2  response valid per port
- resp_rdata  out  INSTR_MEM_WIDTH  response data, shared by both ports
- resp_tag  out  XLEN  response tag, shared by both ports
- err_unexpected  out  1  sticky: response arrived with routing FIFO empty

## Operation
- **Outstanding count.**
  - cnt = requests accepted but not yet answered.
  - Includes the request held in the output register.
- **Acceptance.** A port may be granted only when cnt < MAX_OUTSTANDING.
  - At most one grant per cycle.
  - req_ready is asserted only to the granted port.
  - req_ready is combinational from req_valid, cnt and the priority pointer.
- **Arbitration.** Round-robin via a 1-bit last-grant pointer.
  - When both ports are valid, the port not granted last wins.
  - After reset the pointer favours fetch.
  - A single valid port wins whenever a slot is free.
- **On acceptance.**
  - The address and tag are loaded into the output register.
  - {port_id, discard=0} is pushed into the routing FIFO.
  - cnt increments.
- **Response.** When instr_mem_rdata_valid is high:
  - Pop the FIFO head and decrement cnt.
  - If head.discard = 0, assert resp_valid[head.port_id] combinationally.
  - resp_rdata/resp_tag pass through from the memory unchanged.
  - If head.discard = 1, drop the response; no resp_valid.
- **Simultaneous accept and response.** cnt stays unchanged. A full FIFO does not use the pop to free a slot in the same cycle: ready is computed from the registered cnt.
- **fetch_flush.**
  - Sets discard on every FIFO entry with port_id 0, including the entry being popped this cycle (that response is dropped).
  - A fetch request accepted in the same cycle is not discarded; it belongs to the new stream.
  - Aux entries are unaffected.
- **Unexpected response.** A response with the FIFO empty sets err_unexpected, which stays set until rst. cnt stays at 0 and no resp_valid is raised.
- **Reset.**
  - Outputs: req_ready=0, instr_mem_addr_valid=0, instr_mem_addr=0, instr_mem_tag_out=0, resp_valid=0, err_unexpected=0.
  - State: cnt=0, FIFO empty, pointer favours fetch.
  - Reset mid-operation abandons all in-flight entries; responses arriving after reset raise err_unexpected.

## Timing
- Request accepted in cycle N → instr_mem_addr_valid/addr/tag_out high for exactly cycle N+1 (one-cycle pulse per grant).
- Back-to-back grants give a continuous strobe.
- Response path: zero added latency (combinational routing).
- Throughput: one request per cycle while cnt < MAX_OUTSTANDING.
- Memory latency ≥ 1 cycle after the address strobe.

## Configuration
- IMEM_ARBITER_PERF_EN defined: adds read-only outputs, all cleared by rst and saturating at all-ones:
  - perf_grants0, perf_grants1, 32 bits each: grants per port.
  - perf_full_stalls, 32 bits: cycles with any req_valid high and cnt = MAX_OUTSTANDING.
- Not defined: the ports and counters do not exist; functional behaviour is identical.

## Structure
- Shared package holds:
  - the port-id enum (PORT_FETCH=0, PORT_AUX=1)
  - the routing-entry struct {port_id, discard}
  - the MAX_OUTSTANDING default
- One sub-module, imem_route_fifo: synchronous FIFO of routing entries with push, pop, empty, full and a flush-mark operation that sets discard on all port-0 entries.
- Arbitration and output register stay in the top module.

## Test plan
- Fetch only, memory latency 2, 8 back-to-back requests at addr 0x0,0x4,… → addr_valid continuous from cycle 1, 8 resp_valid[0] with matching tags in order.
- Both ports always valid → grants alternate fetch, aux, fetch…; first grant after reset goes to fetch; responses routed to the correct port.
- Memory withholds responses, MAX_OUTSTANDING=4 → 4 grants, then req_ready=0 until the first response; the stall cycle does not regrant.
- fetch_flush with 2 fetch and 1 aux in flight → both fetch responses dropped, aux response delivered; a fetch request accepted in the flush cycle is delivered normally.
- rdata_valid pulse with nothing in flight → err_unexpected rises and stays high; no resp_valid; cnt remains 0.
- Assert rst with 3 requests in flight → all outputs 0 the next cycle; a late response sets err_unexpected; with IMEM_ARBITER_PERF_EN defined, counters read 0.
